// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_W       = 3;

  localparam logic [WORD_W-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_IF_RD,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    LEN_BYTE     = 2'b00,
    LEN_HALF     = 2'b01,
    LEN_WORD     = 2'b10,
    LEN_WORD_ALT = 2'b11
  } len_e;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // Transaction context captured at grant time.
  typedef struct packed {
    logic [WORD_W-1:0] wdata;
    logic [CNT_W-1:0]  nbytes;
    req_e              who;
  } txn_t;

  function automatic logic [CNT_W-1:0] len_to_bytes(input logic [1:0] len);
    case (len_e'(len))
      LEN_BYTE: return CNT_W'(1);
      LEN_HALF: return CNT_W'(2);
      default:  return CNT_W'(4);
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, load/store and byte-RAM signal bundle around the memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::INST_ADDR_W
);
  import mem_arbiter_pkg::*;

  logic                if_req_i;
  logic [ADDR_W-1:0]   if_addr_i;
  logic                if_flush_i;
  logic [WORD_W-1:0]   if_inst_o;
  logic                if_done_o;

  logic                mem_req_i;
  logic                mem_we_i;
  logic [1:0]          mem_len_i;
  logic [ADDR_W-1:0]   mem_addr_i;
  logic [WORD_W-1:0]   mem_wdata_i;
  logic [WORD_W-1:0]   mem_rdata_o;
  logic                mem_done_o;

  logic [ADDR_W-1:0]   ram_addr_o;
  logic                ram_wr_o;
  logic [BYTE_W-1:0]   ram_wdata_o;
  logic [BYTE_W-1:0]   ram_rdata_i;

  logic                stall_req_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    output if_inst_o, if_done_o,
    input  mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    output mem_rdata_o, mem_done_o,
    output ram_addr_o, ram_wr_o, ram_wdata_o,
    input  ram_rdata_i,
    output stall_req_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    input  if_inst_o, if_done_o,
    output mem_req_i, mem_we_i, mem_len_i, mem_addr_i, mem_wdata_i,
    input  mem_rdata_o, mem_done_o,
    input  ram_addr_o, ram_wr_o, ram_wdata_o,
    output ram_rdata_i,
    input  stall_req_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide synchronous RAM port between instruction fetch and the
// memory stage, sequencing each access as little-endian byte transfers.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  txn_t               txn_q, txn_d;
  logic               kill_q, kill_d;
  logic [WORD_W-1:0]  asm_q, asm_d;

  logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
  logic               ram_wr_q, ram_wr_d;
  logic [BYTE_W-1:0]  ram_wdata_q, ram_wdata_d;
  logic [WORD_W-1:0]  if_inst_q, if_inst_d;
  logic               if_done_q, if_done_d;
  logic [WORD_W-1:0]  mem_rdata_q, mem_rdata_d;
  logic               mem_done_q, mem_done_d;

  logic [CNT_W-1:0]   cnt_inc;
  logic [1:0]         rd_lane;
  logic [1:0]         wr_lane;
  logic [WORD_W-1:0]  asm_ins;

  // In read states the byte on ram_rdata_i belongs to the address issued one cycle earlier.
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign rd_lane = cnt_q[1:0] - 2'd1;
  assign wr_lane = cnt_inc[1:0];

  always_comb begin
    asm_ins = asm_q;
    asm_ins[{rd_lane, 3'b000} +: BYTE_W] = bus.ram_rdata_i;
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    txn_d       = txn_q;
    kill_d      = kill_q;
    asm_d       = asm_q;
    ram_addr_d  = ram_addr_q;
    ram_wr_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if_inst_d   = ZERO_WORD;
    if_done_d   = 1'b0;
    mem_rdata_d = ZERO_WORD;
    mem_done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        kill_d = 1'b0;
        cnt_d  = '0;
        asm_d  = ZERO_WORD;
        if (bus.mem_req_i) begin
          base_d     = bus.mem_addr_i;
          ram_addr_d = bus.mem_addr_i;
          txn_d      = '{wdata: bus.mem_wdata_i, nbytes: len_to_bytes(bus.mem_len_i), who: REQ_MEM};
          if (bus.mem_we_i) begin
            state_d     = ST_MEM_WR;
            ram_wr_d    = 1'b1;
            ram_wdata_d = bus.mem_wdata_i[BYTE_W-1:0];
          end else begin
            state_d = ST_MEM_RD;
          end
        end else if (bus.if_req_i) begin
          base_d     = bus.if_addr_i;
          ram_addr_d = bus.if_addr_i;
          txn_d      = '{wdata: ZERO_WORD, nbytes: CNT_W'(4), who: REQ_IF};
          state_d    = ST_IF_RD;
        end
      end

      ST_IF_RD, ST_MEM_RD: begin
        if ((state_q == ST_IF_RD) && bus.if_flush_i) kill_d = 1'b1;
        if (cnt_q != '0) asm_d = asm_ins;
        if (cnt_q == txn_q.nbytes) begin
          state_d = ST_DONE;
          if (txn_q.who == REQ_IF) begin
            if_done_d = ~kill_d;
            if_inst_d = kill_d ? ZERO_WORD : asm_ins;
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = asm_ins;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc < txn_q.nbytes) ram_addr_d = base_q + ADDR_W'(cnt_inc);
        end
      end

      ST_MEM_WR: begin
        if (cnt_inc < txn_q.nbytes) begin
          cnt_d       = cnt_inc;
          ram_addr_d  = base_q + ADDR_W'(cnt_inc);
          ram_wr_d    = 1'b1;
          ram_wdata_d = txn_q.wdata[{wr_lane, 3'b000} +: BYTE_W];
        end else begin
          state_d    = ST_DONE;
          mem_done_d = 1'b1;
        end
      end

      ST_DONE: begin
        if ((txn_q.who == REQ_IF) && bus.if_flush_i) kill_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      base_q      <= '0;
      txn_q       <= '{wdata: ZERO_WORD, nbytes: '0, who: REQ_IF};
      kill_q      <= 1'b0;
      asm_q       <= ZERO_WORD;
      ram_addr_q  <= '0;
      ram_wr_q    <= 1'b0;
      ram_wdata_q <= '0;
      if_inst_q   <= ZERO_WORD;
      if_done_q   <= 1'b0;
      mem_rdata_q <= ZERO_WORD;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      txn_q       <= txn_d;
      kill_q      <= kill_d;
      asm_q       <= asm_d;
      ram_addr_q  <= ram_addr_d;
      ram_wr_q    <= ram_wr_d;
      ram_wdata_q <= ram_wdata_d;
      if_inst_q   <= if_inst_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign bus.ram_addr_o  = ram_addr_q;
  assign bus.ram_wr_o    = ram_wr_q;
  assign bus.ram_wdata_o = ram_wdata_q;
  assign bus.if_inst_o   = if_inst_q;
  assign bus.if_done_o   = if_done_q;
  assign bus.mem_rdata_o = mem_rdata_q;
  assign bus.mem_done_o  = mem_done_q;

  // Stall follows the requests directly so the pipeline freezes in the request cycle.
  assign bus.stall_req_o = (bus.if_req_i & ~if_done_q) | (bus.mem_req_i & ~mem_done_q);

endmodule
